// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer (master) and the shared MIPS datapath (slave).
// Carries the IR fields and memory handshake in, and every datapath enable/select out.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       retire;
  logic       fault;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, retire, fault
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, retire, fault
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: fetch/decode/execute/memory/writeback over a shared datapath,
// with a ready-handshaked memory port, a wait timeout and a sticky fault trap.
//
// state      | meaning
// -----------+------------------------------------------------------------
// FETCH      | read instruction at PC, PC <= PC+4 when memory completes
// DECODE     | read registers, ALUOut <= branch target, dispatch on opcode
// MEM_ADDR   | ALUOut <= A + sign-ext imm (lw/sw address)
// MEM_READ   | read data memory at ALUOut into MDR
// MEM_WB     | rt <= MDR
// MEM_WRITE  | write B to data memory at ALUOut
// R_EXEC     | ALUOut <= A op B (funct)
// R_WB       | rd <= ALUOut
// BRANCH     | compare A/B, PC <= ALUOut when taken
// JUMP       | PC <= jump address
// I_EXEC     | ALUOut <= A op imm
// I_WB       | rt <= ALUOut
// JAL        | $31 <= PC, PC <= jump address
// JR         | PC <= A
// LUI        | rt <= {imm,16'b0}
// FAULT      | illegal opcode or memory timeout; held until reset
module multicycle_control #(
  parameter int WAIT_W      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                  clock,
  input logic                  rst_n,
  multicycle_control_if.master ctl
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_LUI       = 4'd14,
    S_FAULT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_JR    = 6'd8;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_FUNC = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;
  localparam logic [2:0] ALU_SLT  = 3'd6;

  localparam logic [2:0] SRCB_B     = 3'd0;
  localparam logic [2:0] SRCB_FOUR  = 3'd1;
  localparam logic [2:0] SRCB_SIMM  = 3'd2;
  localparam logic [2:0] SRCB_SIMM2 = 3'd3;
  localparam logic [2:0] SRCB_ZIMM  = 3'd4;

  localparam logic [1:0] PCS_ALU  = 2'd0;
  localparam logic [1:0] PCS_OUT  = 2'd1;
  localparam logic [1:0] PCS_JUMP = 2'd2;
  localparam logic [1:0] PCS_REG  = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;
  localparam logic [1:0] WB_LUI    = 2'd3;

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  state_t            state_q;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_q;
  logic              run_q;
  logic              mem_wait;
  logic              timed_out;

  assign mem_wait  = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);
  assign timed_out = mem_wait && !ctl.mem_ready && (wait_q == TIMEOUT_CNT);

  always_comb begin
    next_state = state_q;
    case (state_q)
      S_FETCH:     if (ctl.mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (ctl.opcode)
          OP_RTYPE:                next_state = (ctl.funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW:            next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:          next_state = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI:         next_state = S_I_EXEC;
          OP_LUI:                  next_state = S_LUI;
          OP_J:                    next_state = S_JUMP;
          OP_JAL:                  next_state = S_JAL;
          default:                 next_state = S_FAULT;
        endcase
      end
      S_MEM_ADDR:  next_state = (ctl.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (ctl.mem_ready) next_state = S_MEM_WB;
      S_MEM_WRITE: if (ctl.mem_ready) next_state = S_FETCH;
      S_R_EXEC:    next_state = S_R_WB;
      S_I_EXEC:    next_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP,
      S_I_WB, S_JAL, S_JR, S_LUI:
                   next_state = S_FETCH;
      S_FAULT:     next_state = S_FAULT;
      default:     next_state = S_FAULT;
    endcase
    if (timed_out) next_state = S_FAULT;
  end

  // run_q holds off the first fetch until the first edge after reset release and,
  // being cleared asynchronously, drops every enable the instant reset asserts.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      run_q   <= 1'b0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      state_q <= next_state;
      if (next_state != state_q)
        wait_q <= '0;
      else if (mem_wait && !ctl.mem_ready)
        wait_q <= wait_q + 1'b1;
    end
  end

  assign ctl.state = state_q;

  always_comb begin
    ctl.PCWrite     = 1'b0;
    ctl.PCWriteCond = 1'b0;
    ctl.BranchNe    = 1'b0;
    ctl.IorD        = 1'b0;
    ctl.MemRead     = 1'b0;
    ctl.MemWrite    = 1'b0;
    ctl.IRWrite     = 1'b0;
    ctl.RegDst      = DST_RT;
    ctl.MemtoReg    = WB_ALUOUT;
    ctl.RegWrite    = 1'b0;
    ctl.ALUSrcA     = 1'b0;
    ctl.ALUSrcB     = SRCB_B;
    ctl.ALUOp       = ALU_ADD;
    ctl.PCSource    = PCS_ALU;
    ctl.retire      = 1'b0;
    ctl.fault       = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          ctl.MemRead  = 1'b1;
          ctl.ALUSrcB  = SRCB_FOUR;
          ctl.IRWrite  = ctl.mem_ready;
          ctl.PCWrite  = ctl.mem_ready;
        end
        S_DECODE:    ctl.ALUSrcB = SRCB_SIMM2;
        S_MEM_ADDR: begin
          ctl.ALUSrcA = 1'b1;
          ctl.ALUSrcB = SRCB_SIMM;
        end
        S_MEM_READ: begin
          ctl.MemRead = 1'b1;
          ctl.IorD    = 1'b1;
        end
        S_MEM_WB: begin
          ctl.MemtoReg = WB_MDR;
          ctl.RegWrite = 1'b1;
          ctl.retire   = 1'b1;
        end
        S_MEM_WRITE: begin
          ctl.MemWrite = 1'b1;
          ctl.IorD     = 1'b1;
          ctl.retire   = ctl.mem_ready;
        end
        S_R_EXEC: begin
          ctl.ALUSrcA = 1'b1;
          ctl.ALUOp   = ALU_FUNC;
        end
        S_R_WB: begin
          ctl.RegDst   = DST_RD;
          ctl.RegWrite = 1'b1;
          ctl.retire   = 1'b1;
        end
        S_BRANCH: begin
          ctl.ALUSrcA     = 1'b1;
          ctl.ALUOp       = ALU_SUB;
          ctl.PCWriteCond = 1'b1;
          ctl.BranchNe    = ctl.opcode[0];
          ctl.PCSource    = PCS_OUT;
          ctl.retire      = 1'b1;
        end
        S_I_EXEC: begin
          ctl.ALUSrcA = 1'b1;
          case (ctl.opcode)
            OP_ADDI: begin ctl.ALUSrcB = SRCB_SIMM; ctl.ALUOp = ALU_ADD; end
            OP_SLTI: begin ctl.ALUSrcB = SRCB_SIMM; ctl.ALUOp = ALU_SLT; end
            OP_ANDI: begin ctl.ALUSrcB = SRCB_ZIMM; ctl.ALUOp = ALU_AND; end
            OP_ORI:  begin ctl.ALUSrcB = SRCB_ZIMM; ctl.ALUOp = ALU_OR;  end
            OP_XORI: begin ctl.ALUSrcB = SRCB_ZIMM; ctl.ALUOp = ALU_XOR; end
            default: ;
          endcase
        end
        S_I_WB: begin
          ctl.RegWrite = 1'b1;
          ctl.retire   = 1'b1;
        end
        S_LUI: begin
          ctl.MemtoReg = WB_LUI;
          ctl.RegWrite = 1'b1;
          ctl.retire   = 1'b1;
        end
        S_JUMP: begin
          ctl.PCWrite  = 1'b1;
          ctl.PCSource = PCS_JUMP;
          ctl.retire   = 1'b1;
        end
        // PC already holds PC+4 from fetch, so the link value is the register's current contents.
        S_JAL: begin
          ctl.RegDst   = DST_RA;
          ctl.MemtoReg = WB_PC;
          ctl.RegWrite = 1'b1;
          ctl.PCWrite  = 1'b1;
          ctl.PCSource = PCS_JUMP;
          ctl.retire   = 1'b1;
        end
        S_JR: begin
          ctl.PCWrite  = 1'b1;
          ctl.PCSource = PCS_REG;
          ctl.retire   = 1'b1;
        end
        S_FAULT:     ctl.fault = 1'b1;
        default:     ctl.fault = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: stimulus pushes hand-derived per-cycle expectations,
// a monitor pops and compares them against the live control outputs.
module tb_multicycle_control;

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  multicycle_control_if bus();

  multicycle_control #(.WAIT_W(4), .MEM_TIMEOUT(15)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  typedef struct {
    logic [3:0]  st;
    logic [20:0] w;
    logic        ret;
    logic        flt;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  event        async_chk;
  logic [5:0]  cur_op;
  logic [5:0]  cur_fn;

  logic [20:0] W_ZERO, W_F1, W_F0, W_DEC, W_REX, W_RWB, W_MA, W_MR, W_MWB, W_MW;
  logic [20:0] W_BNE, W_BEQ, W_IWB, W_LUI, W_J, W_JAL, W_JR;
  logic [20:0] W_IEX[5];
  logic [5:0]  IOPS[5];

  // field order: pcw pcwc bne iord mr mw irw regdst memtoreg rw srca srcb aluop pcsrc
  function automatic logic [20:0] cw(input int pcw, input int pcwc, input int bne,
                                     input int iord, input int mr, input int mw,
                                     input int irw, input int rdst, input int mtr,
                                     input int rw, input int srca, input int srcb,
                                     input int aluop, input int pcsrc);
    return {pcw[0], pcwc[0], bne[0], iord[0], mr[0], mw[0], irw[0], rdst[1:0], mtr[1:0],
            rw[0], srca[0], srcb[2:0], aluop[2:0], pcsrc[1:0]};
  endfunction

  function automatic logic [20:0] act_word();
    return {bus.PCWrite, bus.PCWriteCond, bus.BranchNe, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUOp, bus.PCSource};
  endfunction

  task automatic chk(input string name, input string fld, input logic [20:0] act,
                     input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, fld, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock or async_chk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.name, "state",  21'(bus.state),  21'(e.st));
        chk(e.name, "ctrl",   act_word(),      e.w);
        chk(e.name, "retire", 21'(bus.retire), 21'(e.ret));
        chk(e.name, "fault",  21'(bus.fault),  21'(e.flt));
      end
    end
  end

  task automatic push(input int st, input logic [20:0] w, input int ret, input int flt,
                      input string name);
    exp_t e;
    e.st   = 4'(st);
    e.w    = w;
    e.ret  = 1'(ret);
    e.flt  = 1'(flt);
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input int st, input logic [20:0] w, input int ret, input int flt,
                      input int rdy, input string name);
    @(posedge clock);
    #1;
    bus.mem_ready = 1'(rdy);
    bus.opcode    = cur_op;
    bus.funct     = cur_fn;
    push(st, w, ret, flt, name);
  endtask

  task automatic reset_cycle(input string name);
    step(0, W_ZERO, 0, 0, 1, name);
    @(negedge clock);
    #1 rst_n = 1'b1;
  endtask

  task automatic enter_reset();
    @(negedge clock);
    #1 rst_n = 1'b0;
  endtask

  task automatic fetch_decode(input string name);
    step(0, W_F1, 0, 0, 1, {name, "_fetch"});
    step(1, W_DEC, 0, 0, 1, {name, "_dec"});
  endtask

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stimulus
    W_ZERO = '0;
    W_F1   = cw(1,0,0,0,1,0,1, 0,0,0,0, 1,0,0);
    W_F0   = cw(0,0,0,0,1,0,0, 0,0,0,0, 1,0,0);
    W_DEC  = cw(0,0,0,0,0,0,0, 0,0,0,0, 3,0,0);
    W_REX  = cw(0,0,0,0,0,0,0, 0,0,0,1, 0,2,0);
    W_RWB  = cw(0,0,0,0,0,0,0, 1,0,1,0, 0,0,0);
    W_MA   = cw(0,0,0,0,0,0,0, 0,0,0,1, 2,0,0);
    W_MR   = cw(0,0,0,1,1,0,0, 0,0,0,0, 0,0,0);
    W_MWB  = cw(0,0,0,0,0,0,0, 0,1,1,0, 0,0,0);
    W_MW   = cw(0,0,0,1,0,1,0, 0,0,0,0, 0,0,0);
    W_BNE  = cw(0,1,1,0,0,0,0, 0,0,0,1, 0,1,1);
    W_BEQ  = cw(0,1,0,0,0,0,0, 0,0,0,1, 0,1,1);
    W_IWB  = cw(0,0,0,0,0,0,0, 0,0,1,0, 0,0,0);
    W_LUI  = cw(0,0,0,0,0,0,0, 0,3,1,0, 0,0,0);
    W_J    = cw(1,0,0,0,0,0,0, 0,0,0,0, 0,0,2);
    W_JAL  = cw(1,0,0,0,0,0,0, 2,2,1,0, 0,0,2);
    W_JR   = cw(1,0,0,0,0,0,0, 0,0,0,0, 0,0,3);
    IOPS[0] = 6'd13; W_IEX[0] = cw(0,0,0,0,0,0,0, 0,0,0,1, 4,3,0);
    IOPS[1] = 6'd8;  W_IEX[1] = cw(0,0,0,0,0,0,0, 0,0,0,1, 2,0,0);
    IOPS[2] = 6'd10; W_IEX[2] = cw(0,0,0,0,0,0,0, 0,0,0,1, 2,6,0);
    IOPS[3] = 6'd12; W_IEX[3] = cw(0,0,0,0,0,0,0, 0,0,0,1, 4,4,0);
    IOPS[4] = 6'd14; W_IEX[4] = cw(0,0,0,0,0,0,0, 0,0,0,1, 4,5,0);

    rst_n = 1'b0;
    bus.opcode = 6'd0; bus.funct = 6'd32; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    cur_op = 6'd0; cur_fn = 6'd32;
    reset_cycle("rst_init");

    repeat (2) begin
      fetch_decode("add");
      step(6, W_REX, 0, 0, 1, "add_exec");
      step(7, W_RWB, 1, 0, 1, "add_wb");
    end

    cur_op = 6'd35;
    fetch_decode("lw");
    step(2, W_MA, 0, 0, 1, "lw_addr");
    repeat (3) step(3, W_MR, 0, 0, 0, "lw_wait");
    step(3, W_MR, 0, 0, 1, "lw_read");
    step(4, W_MWB, 1, 0, 1, "lw_wb");

    cur_op = 6'd43;
    fetch_decode("sw");
    step(2, W_MA, 0, 0, 1, "sw_addr");
    step(5, W_MW, 0, 0, 0, "sw_wait");
    step(5, W_MW, 1, 0, 1, "sw_write");

    cur_op = 6'd5;
    fetch_decode("bne");
    step(8, W_BNE, 1, 0, 1, "bne_br");
    cur_op = 6'd4;
    fetch_decode("beq");
    step(8, W_BEQ, 1, 0, 1, "beq_br");

    for (int i = 0; i < 5; i++) begin
      cur_op = IOPS[i];
      fetch_decode($sformatf("imm%0d", IOPS[i]));
      step(10, W_IEX[i], 0, 0, 1, $sformatf("imm%0d_exec", IOPS[i]));
      step(11, W_IWB, 1, 0, 1, $sformatf("imm%0d_wb", IOPS[i]));
    end

    cur_op = 6'd15;
    fetch_decode("lui");
    step(14, W_LUI, 1, 0, 1, "lui_wb");

    cur_op = 6'd2;
    repeat (2) step(0, W_F0, 0, 0, 0, "j_fetch_wait");
    fetch_decode("j");
    step(9, W_J, 1, 0, 1, "j_jump");

    cur_op = 6'd3;
    fetch_decode("jal");
    step(12, W_JAL, 1, 0, 1, "jal_link");

    cur_op = 6'd0; cur_fn = 6'd8;
    fetch_decode("jr");
    step(13, W_JR, 1, 0, 1, "jr_jump");

    // ready arriving in the last allowed wait cycle still completes the fetch
    cur_op = 6'd2;
    repeat (15) step(0, W_F0, 0, 0, 0, "late_wait");
    fetch_decode("late");
    step(9, W_J, 1, 0, 1, "late_jump");

    cur_op = 6'd0; cur_fn = 6'd32;
    repeat (16) step(0, W_F0, 0, 0, 0, "tmo_wait");
    step(15, W_ZERO, 0, 1, 0, "tmo_fault");
    step(15, W_ZERO, 0, 1, 1, "tmo_sticky");
    step(15, W_ZERO, 0, 1, 0, "tmo_sticky2");
    enter_reset();
    reset_cycle("rst_fault");

    cur_op = 6'd2;
    fetch_decode("post_rst");
    step(9, W_J, 1, 0, 1, "post_rst_jump");

    cur_op = 6'd63;
    fetch_decode("illegal");
    step(15, W_ZERO, 0, 1, 1, "illegal_fault");
    step(15, W_ZERO, 0, 1, 1, "illegal_sticky");
    enter_reset();
    reset_cycle("rst_illegal");

    cur_op = 6'd43;
    fetch_decode("sw_rst");
    step(2, W_MA, 0, 0, 1, "sw_rst_addr");
    step(5, W_MW, 0, 0, 0, "sw_rst_hold");
    @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    push(0, W_ZERO, 0, 0, "async_rst");
    -> async_chk;
    reset_cycle("rst_async");

    cur_op = 6'd0; cur_fn = 6'd32;
    fetch_decode("final_add");
    step(6, W_REX, 0, 0, 1, "final_exec");
    step(7, W_RWB, 1, 0, 1, "final_wb");

    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
